// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle one-bit-per-clock shifter with start/busy/done handshake
//
// Shifts a WIDTH-bit operand by `amount` single-bit steps, one step per clock.
// Supports left and right shifts in logical, arithmetic, rotate and serial-fill modes.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request, accepted only when idle
//   dir         in   0 = left (toward MSB), 1 = right (toward LSB)
//   mode        in   00 logical, 01 arithmetic, 10 rotate, 11 serial fill
//   amount      in   number of single-bit shifts (AMT_W bits)
//   data_in     in   operand, captured on accept
//   ser_in_lsb  in   fill bit for left shifts in serial mode, sampled each shift cycle
//   ser_in_msb  in   fill bit for right shifts in serial mode, sampled each shift cycle
//   result      out  working/final value
//   bb_out      out  last bit shifted out
//   busy        out  high while not idle
//   done        out  one-cycle pulse when result is final
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_lsb,
    input  logic             ser_in_msb,
    output logic [WIDTH-1:0] result,
    output logic             bb_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    localparam logic [1:0] MODE_SER = 2'b11;

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             bb_q;
    logic             busy_q;
    logic             done_q;
    logic [AMT_W-1:0] cnt_q;
    logic             dir_q;
    logic [1:0]       mode_q;

    logic [WIDTH-1:0] shift_d;
    logic             shout_d;
    logic             fill_d;

    // One-step shift of the working value, using the captured dir/mode.
    // Arithmetic left falls into the default (zero fill) like logical left.
    always_comb begin
        shift_d = result_q;
        shout_d = 1'b0;
        fill_d  = 1'b0;
        if (!dir_q) begin
            shout_d = result_q[WIDTH-1];
            case (mode_q)
                MODE_ROT: fill_d = result_q[WIDTH-1];
                MODE_SER: fill_d = ser_in_lsb;
                default:  fill_d = 1'b0;
            endcase
            shift_d = {result_q[WIDTH-2:0], fill_d};
        end else begin
            shout_d = result_q[0];
            case (mode_q)
                MODE_LOG: fill_d = 1'b0;
                MODE_ARI: fill_d = result_q[WIDTH-1];
                MODE_ROT: fill_d = result_q[0];
                MODE_SER: fill_d = ser_in_msb;
                default:  fill_d = 1'b0;
            endcase
            shift_d = {fill_d, result_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            bb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            mode_q   <= MODE_LOG;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        result_q <= data_in;
                        cnt_q    <= amount;
                        dir_q    <= dir;
                        mode_q   <= mode;
                        bb_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        if (amount == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    result_q <= shift_d;
                    bb_q     <= shout_d;
                    cnt_q    <= cnt_q - AMT_W'(1);
                    // Last step: the pulse is registered so it appears with the final value.
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign bb_out = bb_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - directed self-checking bench for seq_shift_unit
module tb_seq_shift_unit;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             ser_in_lsb;
    logic             ser_in_msb;
    logic [WIDTH-1:0] result;
    logic             bb_out;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dir        (dir),
        .mode       (mode),
        .amount     (amount),
        .data_in    (data_in),
        .ser_in_lsb (ser_in_lsb),
        .ser_in_msb (ser_in_msb),
        .result     (result),
        .bb_out     (bb_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and follows it to done. ser_pat bit k-1 is driven on
    // both serial inputs during shift cycle k. If poke is nonzero, a conflicting
    // start with different operands is asserted in that busy cycle.
    task automatic run_op(input string tag, input logic [7:0] d, input logic dr,
                          input logic [1:0] md, input logic [2:0] amt,
                          input logic [7:0] ser_pat, input int poke,
                          input logic [7:0] exp_res, input logic exp_bb);
        int cyc;
        bit seen;
        data_in = d;
        dir     = dr;
        mode    = md;
        amount  = amt;
        start   = 1'b1;
        step();
        start = 1'b0;
        cyc   = 1;
        seen  = 1'b0;
        while (cyc <= 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            check({tag, " busy"}, 32'(busy), 32'd1);
            if (cyc <= 8) begin
                ser_in_lsb = ser_pat[3'(cyc - 1)];
                ser_in_msb = ser_pat[3'(cyc - 1)];
            end
            if (cyc == poke) begin
                start   = 1'b1;
                data_in = ~d;
                amount  = 3'd1;
                dir     = ~dr;
                mode    = ~md;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " done_cycle"}, 32'(cyc), 32'(amt) + 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd1);
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " bb_out"}, 32'(bb_out), 32'(exp_bb));
        step();
        check({tag, " done_pulse_end"}, 32'(done), 32'd0);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " result_hold"}, 32'(result), 32'(exp_res));
        check({tag, " bb_hold"}, 32'(bb_out), 32'(exp_bb));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        dir        = 1'b0;
        mode       = 2'b00;
        amount     = '0;
        data_in    = '0;
        ser_in_lsb = 1'b0;
        ser_in_msb = 1'b0;
        repeat (2) step();
        check("reset result", 32'(result), 32'd0);
        check("reset bb_out", 32'(bb_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();

        // logical left 3
        run_op("lsl3", 8'hB3, 1'b0, 2'b00, 3'd3, 8'h00, 0, 8'h98, 1'b1);
        // arithmetic right 2 and 7
        run_op("asr2", 8'hB3, 1'b1, 2'b01, 3'd2, 8'h00, 0, 8'hEC, 1'b1);
        run_op("asr7", 8'hB3, 1'b1, 2'b01, 3'd7, 8'h00, 0, 8'hFF, 1'b0);
        // rotate left 1, rotate right 4
        run_op("rol1", 8'h81, 1'b0, 2'b10, 3'd1, 8'h00, 0, 8'h03, 1'b1);
        run_op("ror4", 8'h81, 1'b1, 2'b10, 3'd4, 8'h00, 0, 8'h18, 1'b0);
        // serial left fill 1,0,1,1 and serial right fill 1,0,1
        run_op("serl4", 8'h00, 1'b0, 2'b11, 3'd4, 8'b0000_1101, 0, 8'h0B, 1'b0);
        run_op("serr3", 8'h00, 1'b1, 2'b11, 3'd3, 8'b0000_0101, 0, 8'hA0, 1'b0);
        // logical right 7 and arithmetic left (same as logical left)
        run_op("lsr7", 8'h80, 1'b1, 2'b00, 3'd7, 8'h00, 0, 8'h01, 1'b0);
        run_op("asl2", 8'hC1, 1'b0, 2'b01, 3'd2, 8'h00, 0, 8'h04, 1'b1);
        // zero amount finishes in cycle 1 with operand untouched
        run_op("amt0", 8'h5A, 1'b0, 2'b00, 3'd0, 8'h00, 0, 8'h5A, 1'b0);
        // start while busy is ignored
        run_op("ignore", 8'h01, 1'b0, 2'b00, 3'd5, 8'h00, 2, 8'h20, 1'b0);
        repeat (3) begin
            step();
            check("ignore no_extra_done", 32'(done), 32'd0);
            check("ignore idle", 32'(busy), 32'd0);
        end

        // asynchronous reset in cycle 2 of an amount=6 shift
        data_in = 8'hFF;
        dir     = 1'b0;
        mode    = 2'b00;
        amount  = 3'd6;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        check("midrst busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst result", 32'(result), 32'd0);
        check("midrst bb_out", 32'(bb_out), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        repeat (3) begin
            step();
            check("midrst no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        step();
        check("after_rst idle", 32'(busy), 32'd0);
        run_op("after_rst", 8'h3C, 1'b1, 2'b00, 3'd2, 8'h00, 0, 8'h0F, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
